// File: rtl/fpa_align_if.sv
// Operand/result handshake bundle for the FP adder alignment sequencer.
// m_small widens to 27 bits (mantissa + G/R/S) when FPA_ALIGN_GRS_EN is defined.
interface fpa_align_if;
`ifdef FPA_ALIGN_GRS_EN
    localparam int MS_W = 27;
`else
    localparam int MS_W = 24;
`endif

    logic            in_valid;
    logic            in_ready;
    logic [7:0]      Ex;
    logic [7:0]      Ey;
    logic [22:0]     Mx;
    logic [22:0]     My;
    logic            out_valid;
    logic            out_ready;
    logic [7:0]      e_out;
    logic [23:0]     m_big;
    logic [MS_W-1:0] m_small;
    logic            swapped;

    modport master (
        output in_valid, Ex, Ey, Mx, My, out_ready,
        input  in_ready, out_valid, e_out, m_big, m_small, swapped
    );

    modport slave (
        input  in_valid, Ex, Ey, Mx, My, out_ready,
        output in_ready, out_valid, e_out, m_big, m_small, swapped
    );
endinterface

// File: rtl/fpa_align_seq.sv
// Multi-cycle exponent alignment for the single-precision adder front end.
// Optional feature macro FPA_ALIGN_GRS_EN: keep guard/round/sticky bits below m_small.
module fpa_align_seq #(
    parameter int STEP = 4,
`ifdef FPA_ALIGN_GRS_EN
    parameter int MAX_SHIFT = 27
`else
    parameter int MAX_SHIFT = 26
`endif
) (
    input  logic        clk,
    input  logic        rst,
    fpa_align_if.slave  bus
);
`ifdef FPA_ALIGN_GRS_EN
    localparam int MS_W = 27;
`else
    localparam int MS_W = 24;
`endif

    typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2} state_t;

    state_t          state_q, state_d;
    logic [7:0]      e_q, e_d;
    logic [23:0]     mbig_q, mbig_d;
    logic [MS_W-1:0] msmall_q, msmall_d;
    logic            swap_q, swap_d;
    logic [4:0]      rem_q, rem_d;

    logic [7:0]      eeff_x, eeff_y, diff;
    logic            x_big;
    logic [23:0]     mant_x, mant_y;
    logic [4:0]      d, amt;

    function automatic logic [4:0] clamp_shift(input logic [7:0] dif);
        if (dif > 8'(MAX_SHIFT)) return 5'(MAX_SHIFT);
        return dif[4:0];
    endfunction

    function automatic logic [MS_W-1:0] load_small(input logic [23:0] mant);
`ifdef FPA_ALIGN_GRS_EN
        return {mant, 3'b000};
`else
        return mant;
`endif
    endfunction

    // Sticky variant shifts one bit at a time so every bit leaving R is folded into S.
    function automatic logic [MS_W-1:0] shr_step(input logic [MS_W-1:0] m, input logic [4:0] n);
`ifdef FPA_ALIGN_GRS_EN
        logic [MS_W-1:0] r;
        r = m;
        for (int i = 0; i < STEP; i++) begin
            if (5'(i) < n) r = {1'b0, r[MS_W-1:2], r[1] | r[0]};
        end
        return r;
`else
        return m >> n;
`endif
    endfunction

    always_comb begin
        eeff_x = (bus.Ex == 8'd0) ? 8'd1 : bus.Ex;
        eeff_y = (bus.Ey == 8'd0) ? 8'd1 : bus.Ey;
        x_big  = (eeff_x >= eeff_y);
        diff   = x_big ? (eeff_x - eeff_y) : (eeff_y - eeff_x);
        d      = clamp_shift(diff);
        mant_x = {|bus.Ex, bus.Mx};
        mant_y = {|bus.Ey, bus.My};
        amt    = (rem_q < 5'(STEP)) ? rem_q : 5'(STEP);

        state_d  = state_q;
        e_d      = e_q;
        mbig_d   = mbig_q;
        msmall_d = msmall_q;
        swap_d   = swap_q;
        rem_d    = rem_q;

        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    e_d      = x_big ? bus.Ex : bus.Ey;
                    mbig_d   = x_big ? mant_x : mant_y;
                    msmall_d = load_small(x_big ? mant_y : mant_x);
                    swap_d   = ~x_big;
                    rem_d    = d;
                    state_d  = (d != 5'd0) ? SHIFT : DONE;
                end
            end
            SHIFT: begin
                msmall_d = shr_step(msmall_q, amt);
                rem_d    = rem_q - amt;
                if (rem_q == amt) state_d = DONE;
            end
            DONE: begin
                if (bus.out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            e_q      <= '0;
            mbig_q   <= '0;
            msmall_q <= '0;
            swap_q   <= 1'b0;
            rem_q    <= '0;
        end else begin
            state_q  <= state_d;
            e_q      <= e_d;
            mbig_q   <= mbig_d;
            msmall_q <= msmall_d;
            swap_q   <= swap_d;
            rem_q    <= rem_d;
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.e_out     = e_q;
    assign bus.m_big     = mbig_q;
    assign bus.m_small   = msmall_q;
    assign bus.swapped   = swap_q;
endmodule

// File: tb/tb_fpa_align_seq.sv
// Table-driven bench for fpa_align_seq (STEP=4) with a scoreboard queue of expected results.
module tb_fpa_align_seq;
    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    fpa_align_if bus ();

    fpa_align_seq dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  ex, ey;
        logic [22:0] mx, my;
        logic [7:0]  e;
        logic [23:0] mb;
        logic [23:0] ms24;
        logic [26:0] ms27;
        logic        sw;
        int          lat;
    } vec_t;

    typedef struct {
        logic [7:0]  e;
        logic [23:0] mb;
        logic [31:0] ms;
        logic        sw;
        int          lat;
    } exp_t;

    exp_t sb[$];
    vec_t tab[9];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    function automatic exp_t mk_exp(input vec_t v);
        exp_t x;
        x.e  = v.e;
        x.mb = v.mb;
`ifdef FPA_ALIGN_GRS_EN
        x.ms = {5'd0, v.ms27};
`else
        x.ms = {8'd0, v.ms24};
`endif
        x.sw  = v.sw;
        x.lat = v.lat;
        return x;
    endfunction

    // Waits for out_valid, pops the scoreboard and compares; leaves time at #1 after the valid edge.
    task automatic collect(input string tag);
        int   cyc;
        exp_t x;
        cyc = 0;
        while (!bus.out_valid && cyc < 64) begin
            @(posedge clk); #1;
            cyc++;
        end
        if (!bus.out_valid) begin
            total++; bad++;
            $display("FAIL %s_timeout actual=no_out_valid required=out_valid", tag);
        end
        x = sb.pop_front();
        chk({tag, "_lat"}, 32'(cyc), 32'(x.lat));
        chk({tag, "_e_out"}, {24'd0, bus.e_out}, {24'd0, x.e});
        chk({tag, "_m_big"}, {8'd0, bus.m_big}, {8'd0, x.mb});
        chk({tag, "_m_small"}, 32'(bus.m_small), x.ms);
        chk({tag, "_swapped"}, {31'd0, bus.swapped}, {31'd0, x.sw});
    endtask

    task automatic drive(input vec_t v);
        @(negedge clk);
        chk("in_ready_idle", {31'd0, bus.in_ready}, 32'd1);
        bus.Ex = v.ex; bus.Ey = v.ey; bus.Mx = v.mx; bus.My = v.my;
        bus.in_valid = 1'b1;
        sb.push_back(mk_exp(v));
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        drive(v);
        collect(tag);
        @(posedge clk); #1;
        chk({tag, "_valid_drop"}, {31'd0, bus.out_valid}, 32'd0);
        chk({tag, "_ready_back"}, {31'd0, bus.in_ready}, 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        //          ex     ey     mx         my         e      mb         ms24       ms27         sw    lat
        tab[0] = '{8'h80, 8'h80, 23'h0,      23'h400000, 8'h80, 24'h800000, 24'hC00000, 27'h6000000, 1'b0, 0};
        tab[1] = '{8'h7F, 8'h85, 23'h7FFFFF, 23'h0,      8'h85, 24'h800000, 24'h03FFFF, 27'h01FFFFF, 1'b1, 2};
        tab[2] = '{8'hFE, 8'h01, 23'h0,      23'h0,      8'hFE, 24'h800000, 24'h000000, 27'h0000001, 1'b0, 7};
        tab[3] = '{8'h01, 8'h00, 23'h0,      23'h2AAAAA, 8'h01, 24'h800000, 24'h2AAAAA, 27'h1555550, 1'b0, 0};
        tab[4] = '{8'h10, 8'h15, 23'h0,      23'h7FFFFF, 8'h15, 24'hFFFFFF, 24'h040000, 27'h0200000, 1'b1, 2};
        tab[5] = '{8'h41, 8'h40, 23'h1,      23'h3,      8'h41, 24'h800001, 24'h400001, 27'h200000C, 1'b0, 1};
        tab[6] = '{8'hFF, 8'h00, 23'h7FFFFF, 23'h7FFFFF, 8'hFF, 24'hFFFFFF, 24'h000000, 27'h0000001, 1'b0, 7};
        tab[7] = '{8'h98, 8'h80, 23'h0,      23'h7FFFFF, 8'h98, 24'h800000, 24'h000000, 27'h0000007, 1'b0, 6};
        tab[8] = '{8'h20, 8'h23, 23'h7FFFFF, 23'h555555, 8'h23, 24'hD55555, 24'h1FFFFF, 27'h0FFFFFF, 1'b1, 1};

        rst = 1'b1;
        bus.in_valid = 1'b0; bus.out_ready = 1'b1;
        bus.Ex = '0; bus.Ey = '0; bus.Mx = '0; bus.My = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
        chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("rst_e_out", {24'd0, bus.e_out}, 32'd0);
        chk("rst_m_big", {8'd0, bus.m_big}, 32'd0);
        chk("rst_m_small", 32'(bus.m_small), 32'd0);
        chk("rst_swapped", {31'd0, bus.swapped}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 9; i++) run_vec(tab[i], $sformatf("vec%0d", i));

        // Backpressure: result must hold and fresh operands must be ignored.
        bus.out_ready = 1'b0;
        drive(tab[1]);
        collect("bp");
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            bus.Ex = 8'h11; bus.Ey = 8'h22; bus.Mx = 23'h123; bus.My = 23'h456;
            bus.in_valid = 1'b1;
            chk("bp_in_ready", {31'd0, bus.in_ready}, 32'd0);
            @(posedge clk); #1;
            chk("bp_hold_valid", {31'd0, bus.out_valid}, 32'd1);
            chk("bp_hold_e", {24'd0, bus.e_out}, 32'h85);
            chk("bp_hold_small", 32'(bus.m_small), mk_exp(tab[1]).ms);
            chk("bp_hold_swapped", {31'd0, bus.swapped}, 32'd1);
        end
        @(negedge clk);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_exit_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("bp_exit_ready", {31'd0, bus.in_ready}, 32'd1);
        @(posedge clk); #1;
        chk("bp_no_ghost", {31'd0, bus.out_valid}, 32'd0);

        // Reset in the middle of a 20-bit alignment.
        @(negedge clk);
        bus.Ex = 8'h94; bus.Ey = 8'h80; bus.Mx = 23'h7FFFFF; bus.My = 23'h7FFFFF;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        chk("abort_busy_ready", {31'd0, bus.in_ready}, 32'd0);
        chk("abort_busy_valid", {31'd0, bus.out_valid}, 32'd0);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("abort_in_ready", {31'd0, bus.in_ready}, 32'd1);
        chk("abort_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("abort_e_out", {24'd0, bus.e_out}, 32'd0);
        chk("abort_m_big", {8'd0, bus.m_big}, 32'd0);
        chk("abort_m_small", 32'(bus.m_small), 32'd0);
        chk("abort_swapped", {31'd0, bus.swapped}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        run_vec(tab[1], "post_abort");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
